// File: rtl/dram_burst_pkg.sv
// Shared types and helpers for the burst DRAM model.
package dram_pkg;

  // Read-side sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BURST = 2'd2
  } state_e;

  // Default geometry, matching the top-level parameter defaults
  localparam int DEF_ADDR_WIDTH = 18;
  localparam int DEF_LEN_WIDTH  = 4;

  // Read request layout at the default geometry, {addr, len}.
  // The top rebuilds the same layout at its own parameter widths.
  typedef struct packed {
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_LEN_WIDTH-1:0]  len;
  } req_t;

  // Bits needed for a down-counter holding values 0..max_val
  function automatic int lat_cnt_w(input int max_val);
    if (max_val < 2) begin
      return 1;
    end else begin
      return $clog2(max_val + 1);
    end
  endfunction

endpackage

// File: rtl/dram_burst_if.sv
// Bus between the DMA side (master) and the burst DRAM model (slave).
interface dram_burst_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 18,
  parameter int LEN_WIDTH  = 4
);
  logic                  en_wr;
  logic [ADDR_WIDTH-1:0] addr_wr;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  en_rd;
  logic [ADDR_WIDTH-1:0] addr_rd;
  logic [LEN_WIDTH-1:0]  len_rd;
  logic                  rd_ready;
  logic                  valid;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  last;
  logic                  ovf;

  modport master (
    output en_wr, addr_wr, data_in, en_rd, addr_rd, len_rd,
    input  rd_ready, valid, data_out, last, ovf
  );

  modport slave (
    input  en_wr, addr_wr, data_in, en_rd, addr_rd, len_rd,
    output rd_ready, valid, data_out, last, ovf
  );
endinterface

// File: rtl/dram_burst_req_fifo.sv
// Synchronous request FIFO with registered full/empty flags.
module req_fifo #(
  parameter int WIDTH = 22,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] store_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full_q, empty_q;
  logic             push_s, pop_s;

  // Qualify push/pop against occupancy and compute next pointers/count
  always_comb begin
    push_s   = push_i && !full_q;
    pop_s    = pop_i && !empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer, count and flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= (cnt_d == CNT_W'(DEPTH));
      empty_q  <= (cnt_d == CNT_W'(0));
    end
  end

  // Entry storage; contents need no reset since the flags gate every use
  always_ff @(posedge clk) begin
    if (push_s) begin
      store_q[wr_ptr_q] <= din_i;
    end
  end

  assign dout_o  = store_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
endmodule

// File: rtl/dram_burst.sv
// Burst DRAM model: single-beat writes, queued burst reads with a fixed
// request-to-first-beat latency, last-beat marker and sticky overflow flag.
module dram_burst
  import dram_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 18,
  parameter int RD_LATENCY  = 4,
  parameter int LEN_WIDTH   = 4,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  dram_burst_if.slave     bus
);
  localparam int LAT_W = lat_cnt_w(RD_LATENCY - 1);
  localparam int OUT_W = $clog2(QUEUE_DEPTH + 1);
  localparam int REQ_W = ADDR_WIDTH + LEN_WIDTH;

  // Popping from IDLE costs one cycle after acceptance, so that path loads
  // one less wait cycle than a pop made back-to-back from the last beat.
  localparam logic [LAT_W-1:0] LAT_FROM_IDLE  =
    LAT_W'((RD_LATENCY > 2) ? (RD_LATENCY - 3) : 0);
  localparam logic [LAT_W-1:0] LAT_FROM_BURST = LAT_W'(RD_LATENCY - 2);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]  len;
  } req_w_t;

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] cur_addr_q;
  logic [LEN_WIDTH-1:0]  beats_left_q;
  logic [LAT_W-1:0]      lat_q;
  logic                  valid_q;
  logic                  last_q;
  logic [DATA_WIDTH-1:0] data_q;

  logic [OUT_W-1:0]      out_cnt_q, out_cnt_d;
  logic                  rd_ready_q;
  logic                  ovf_q;

  req_w_t                push_req_s;
  req_w_t                head_s;
  logic                  fifo_full_s, fifo_empty_s;
  logic                  push_s, pop_s, done_s;

  // Request acceptance, head pop and burst-completion strobes
  always_comb begin
    push_req_s.addr = bus.addr_rd;
    push_req_s.len  = bus.len_rd;
    push_s = bus.en_rd && rd_ready_q && !fifo_full_s;
    done_s = (state_q == ST_BURST) && (beats_left_q == LEN_WIDTH'(0));
    if (state_q == ST_IDLE) begin
      pop_s = !fifo_empty_s;
    end else begin
      pop_s = done_s && !fifo_empty_s;
    end
  end

  req_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (QUEUE_DEPTH)
  ) u_req_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_s),
    .din_i   (push_req_s),
    .pop_i   (pop_s),
    .dout_o  (head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  // Outstanding requests = queued plus the one being served; it reaches
  // QUEUE_DEPTH one request earlier than the FIFO alone would
  always_comb begin
    case ({push_s, done_s})
      2'b10:   out_cnt_d = out_cnt_q + OUT_W'(1);
      2'b01:   out_cnt_d = out_cnt_q - OUT_W'(1);
      default: out_cnt_d = out_cnt_q;
    endcase
  end

  // Registered ready and sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_cnt_q  <= '0;
      rd_ready_q <= 1'b1;
      ovf_q      <= 1'b0;
    end else begin
      out_cnt_q  <= out_cnt_d;
      rd_ready_q <= (out_cnt_d < OUT_W'(QUEUE_DEPTH));
      ovf_q      <= ovf_q | (bus.en_rd & ~rd_ready_q);
    end
  end

  // Write port; memory contents survive reset
  always_ff @(posedge clk) begin
    if (bus.en_wr) begin
      mem_q[bus.addr_wr] <= bus.data_in;
    end
  end

  // Read sequencer: pop, wait out the latency, stream beats.
  // The beat read uses the pre-edge array value, so a same-edge write
  // to the beat address is seen only by later reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cur_addr_q   <= '0;
      beats_left_q <= '0;
      lat_q        <= '0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
      data_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          valid_q <= 1'b0;
          last_q  <= 1'b0;
          if (pop_s) begin
            cur_addr_q   <= head_s.addr;
            beats_left_q <= head_s.len;
            lat_q        <= LAT_FROM_IDLE;
            if (RD_LATENCY <= 2) begin
              state_q <= ST_BURST;
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          valid_q <= 1'b0;
          last_q  <= 1'b0;
          if (lat_q == LAT_W'(0)) begin
            state_q <= ST_BURST;
          end else begin
            lat_q <= lat_q - LAT_W'(1);
          end
        end
        ST_BURST: begin
          valid_q    <= 1'b1;
          data_q     <= mem_q[cur_addr_q];
          last_q     <= done_s;
          cur_addr_q <= cur_addr_q + ADDR_WIDTH'(1);
          if (!done_s) begin
            beats_left_q <= beats_left_q - LEN_WIDTH'(1);
          end else if (pop_s) begin
            cur_addr_q   <= head_s.addr;
            beats_left_q <= head_s.len;
            lat_q        <= LAT_FROM_BURST;
            state_q      <= ST_WAIT;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
          last_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rd_ready = rd_ready_q;
  assign bus.valid    = valid_q;
  assign bus.data_out = data_q;
  assign bus.last     = last_q;
  assign bus.ovf      = ovf_q;
endmodule

// File: tb/tb_dram_burst.sv
// Directed bench for dram_burst: inputs driven and outputs sampled on the
// falling edge; expectations are hand-derived cycle offsets from the
// accepting rising edge.
module tb_dram_burst;
  localparam int DW = 32;
  localparam int AW = 18;
  localparam int RL = 4;
  localparam int LW = 4;
  localparam int QD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dram_burst_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

  dram_burst #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .RD_LATENCY (RL),
    .LEN_WIDTH  (LW),
    .QUEUE_DEPTH(QD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.en_wr   = 1'b1;
    bus.addr_wr = a;
    bus.data_in = d;
    @(negedge clk);
    bus.en_wr   = 1'b0;
  endtask

  task automatic rq(input logic [AW-1:0] a, input logic [LW-1:0] l);
    bus.en_rd   = 1'b1;
    bus.addr_rd = a;
    bus.len_rd  = l;
    @(negedge clk);
    bus.en_rd   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bus.en_wr   = 1'b0;
    bus.addr_wr = '0;
    bus.data_in = '0;
    bus.en_rd   = 1'b0;
    bus.addr_rd = '0;
    bus.len_rd  = '0;

    // Reset values
    idle(2);
    chk("rst_valid", bus.valid, 1'b0);
    chk("rst_last", bus.last, 1'b0);
    chk("rst_data", bus.data_out, 32'h0);
    chk("rst_ovf", bus.ovf, 1'b0);
    chk("rst_ready", bus.rd_ready, 1'b1);
    rst = 1'b0;
    idle(1);
    chk("post_rst_valid", bus.valid, 1'b0);

    // Isolated latency: beat exactly after edge T+4, one cycle wide
    wr(18'd5, 32'hDEADBEEF);
    rq(18'd5, 4'd0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("iso_valid_k%0d", k), bus.valid, (k == 4) ? 1'b1 : 1'b0);
      chk($sformatf("iso_last_k%0d", k), bus.last, (k == 4) ? 1'b1 : 1'b0);
      if (k == 4) begin
        chk("iso_data", bus.data_out, 32'hDEADBEEF);
      end
    end

    // Wrap-around past the top address
    wr(18'h3FFFE, 32'd1);
    wr(18'h3FFFF, 32'd2);
    wr(18'h00000, 32'd3);
    wr(18'h00001, 32'd4);
    rq(18'h3FFFE, 4'd3);
    idle(3);
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("wrap_valid_b%0d", k), bus.valid, (k < 4) ? 1'b1 : 1'b0);
      chk($sformatf("wrap_last_b%0d", k), bus.last, (k == 3) ? 1'b1 : 1'b0);
      if (k < 4) begin
        chk($sformatf("wrap_data_b%0d", k), bus.data_out, 64'(k + 1));
      end
    end

    // Read/write collision returns old data; later read sees new data
    wr(18'd7, 32'hA);
    rq(18'd7, 4'd0);
    idle(3);
    bus.en_wr   = 1'b1;
    bus.addr_wr = 18'd7;
    bus.data_in = 32'hB;
    @(negedge clk);
    bus.en_wr   = 1'b0;
    chk("coll_valid", bus.valid, 1'b1);
    chk("coll_old", bus.data_out, 32'hA);
    idle(1);
    rq(18'd7, 4'd0);
    idle(3);
    @(negedge clk);
    chk("coll_new_valid", bus.valid, 1'b1);
    chk("coll_new", bus.data_out, 32'hB);

    // Queue full: 5 back-to-back len-0 requests, 5th dropped
    idle(2);
    for (int i = 0; i < 8; i++) begin
      wr(AW'(20 + i), DW'(32'h200 + i));
    end
    chk("pre_ovf", bus.ovf, 1'b0);
    bus.en_rd  = 1'b1;
    bus.len_rd = 4'd0;
    for (int i = 0; i < 5; i++) begin
      bus.addr_rd = AW'(20 + i);
      @(negedge clk);
      chk($sformatf("q_ready_%0d", i), bus.rd_ready, (i != 3) ? 1'b1 : 1'b0);
      chk($sformatf("q_ovf_%0d", i), bus.ovf, (i == 4) ? 1'b1 : 1'b0);
    end
    bus.en_rd = 1'b0;
    for (int k = 4; k <= 24; k++) begin
      if (k > 4) begin
        @(negedge clk);
      end
      if ((k <= 16) && (((k - 4) % 4) == 0)) begin
        chk($sformatf("q_valid_k%0d", k), bus.valid, 1'b1);
        chk($sformatf("q_data_k%0d", k), bus.data_out, 64'(32'h200 + (k - 4) / 4));
        chk($sformatf("q_last_k%0d", k), bus.last, 1'b1);
      end else begin
        chk($sformatf("q_valid_k%0d", k), bus.valid, 1'b0);
      end
    end
    chk("q_ovf_sticky", bus.ovf, 1'b1);

    // Reset mid-burst after the 5th beat
    for (int i = 0; i < 16; i++) begin
      wr(AW'(i), DW'(100 + i));
    end
    rq(18'd0, 4'd15);
    idle(3);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("mb_valid_b%0d", k), bus.valid, 1'b1);
      chk($sformatf("mb_data_b%0d", k), bus.data_out, 64'(100 + k));
    end
    rst = 1'b1;
    @(negedge clk);
    chk("mb_rst_valid", bus.valid, 1'b0);
    chk("mb_rst_ovf", bus.ovf, 1'b0);
    chk("mb_rst_ready", bus.rd_ready, 1'b1);
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk($sformatf("mb_quiet_%0d", k), bus.valid, 1'b0);
    end
    rq(18'd2, 4'd0);
    idle(3);
    @(negedge clk);
    chk("mb_new_valid", bus.valid, 1'b1);
    chk("mb_new_last", bus.last, 1'b1);
    chk("mb_new_data", bus.data_out, 32'd102);
    @(negedge clk);
    chk("mb_new_end", bus.valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
